// File: rtl/axis_lane_adder.sv
// Multi-lane AXI-Stream adder/subtractor: two registered stages, full backpressure, tid/tlast pass-through.
// Optional beat/packet counters are built when AXIS_LANE_ADDER_STATS_EN is defined.
module axis_lane_adder #(
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_LANES      = 4,
  parameter int unsigned C_ID_WIDTH   = 8
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  output logic                                   s_axis_tready,
  input  logic                                   s_axis_tvalid,
  input  logic [C_LANES*2*C_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                                   s_axis_tuser,
  input  logic                                   s_axis_tlast,
  input  logic [C_ID_WIDTH-1:0]                  s_axis_tid,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [C_LANES*(C_DATA_WIDTH+1)-1:0]    m_axis_tdata,
  output logic                                   m_axis_tlast,
  output logic [C_ID_WIDTH-1:0]                  m_axis_tid
`ifdef AXIS_LANE_ADDER_STATS_EN
  ,
  output logic [31:0]                            stat_beats,
  output logic [31:0]                            stat_pkts
`endif
);

  localparam int unsigned W     = C_DATA_WIDTH;
  localparam int unsigned RW    = C_DATA_WIDTH + 1;
  localparam int unsigned IN_W  = C_LANES * 2 * C_DATA_WIDTH;
  localparam int unsigned OUT_W = C_LANES * (C_DATA_WIDTH + 1);

  logic                  s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]       s1_data_q,  s1_data_d;
  logic                  s1_op_q,    s1_op_d;
  logic                  s1_last_q,  s1_last_d;
  logic [C_ID_WIDTH-1:0] s1_id_q,    s1_id_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]      s2_data_q,  s2_data_d;
  logic                  s2_last_q,  s2_last_d;
  logic [C_ID_WIDTH-1:0] s2_id_q,    s2_id_d;

  logic                  adv1_c, adv2_c, accept_c;
  logic [OUT_W-1:0]      lane_res_c;

  // Per-lane arithmetic on the S1 operands; operands zero-extended so bit W is carry/borrow.
  for (genvar i = 0; i < C_LANES; i++) begin : g_lane
    logic [RW-1:0] a_ext_c;
    logic [RW-1:0] b_ext_c;
    assign a_ext_c = {1'b0, s1_data_q[2*i*W +: W]};
    assign b_ext_c = {1'b0, s1_data_q[(2*i+1)*W +: W]};
    assign lane_res_c[i*RW +: RW] = s1_op_q ? (a_ext_c - b_ext_c) : (a_ext_c + b_ext_c);
  end

  assign adv2_c        = !s2_valid_q || m_axis_tready;
  assign adv1_c        = !s1_valid_q || adv2_c;
  assign s_axis_tready = adv1_c && !areset;
  assign accept_c      = s_axis_tvalid && s_axis_tready;

  // Stage advance: payload registers only load on a real beat, valids follow the handshake rules.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    s1_last_d  = s1_last_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_last_d  = s2_last_q;
    s2_id_d    = s2_id_q;

    if (adv1_c) begin
      s1_valid_d = accept_c;
    end
    if (accept_c) begin
      s1_data_d = s_axis_tdata;
      s1_op_d   = s_axis_tuser;
      s1_last_d = s_axis_tlast;
      s1_id_d   = s_axis_tid;
    end

    if (adv2_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lane_res_c;
        s2_last_d = s1_last_q;
        s2_id_d   = s1_id_q;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_op_q    <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_last_q  <= 1'b0;
      s2_id_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_op_q    <= s1_op_d;
      s1_last_q  <= s1_last_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_last_q  <= s2_last_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign m_axis_tvalid = s2_valid_q;
  assign m_axis_tdata  = s2_data_q;
  assign m_axis_tlast  = s2_last_q;
  assign m_axis_tid    = s2_id_q;

`ifdef AXIS_LANE_ADDER_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [31:0] pkts_q,  pkts_d;

  // Free-running wrap-around counters of master handshakes and packet ends.
  always_comb begin
    beats_d = beats_q;
    pkts_d  = pkts_q;
    if (s2_valid_q && m_axis_tready) begin
      beats_d = beats_q + 32'd1;
      if (s2_last_q) begin
        pkts_d = pkts_q + 32'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beats_q <= '0;
      pkts_q  <= '0;
    end else begin
      beats_q <= beats_d;
      pkts_q  <= pkts_d;
    end
  end

  assign stat_beats = beats_q;
  assign stat_pkts  = pkts_q;
`endif

endmodule

// File: tb/tb_axis_lane_adder.sv
// Bench for axis_lane_adder: table vectors with hand-computed sums, stream sequences, reset flush, 8-bit single-lane build.
module tb_axis_lane_adder;

  localparam int W     = 32;
  localparam int L     = 4;
  localparam int IDW   = 8;
  localparam int IN_W  = L * 2 * W;
  localparam int OUT_W = L * (W + 1);

  logic               aclk = 1'b0;
  logic               areset;
  logic               s_tready, s_valid, s_user, s_last;
  logic [IN_W-1:0]    s_data;
  logic [IDW-1:0]     s_id;
  logic               m_valid, m_ready, m_last;
  logic [OUT_W-1:0]   m_tdata;
  logic [IDW-1:0]     m_id;

  logic               s8_tready, s8_valid, s8_user, s8_last;
  logic [15:0]        s8_data;
  logic [7:0]         s8_id;
  logic               m8_valid, m8_ready, m8_last;
  logic [8:0]         m8_tdata;
  logic [7:0]         m8_id;
`ifdef AXIS_LANE_ADDER_STATS_EN
  logic [31:0]        stat_beats, stat_pkts, st8_beats, st8_pkts;
`endif

  always #5 aclk = ~aclk;

  axis_lane_adder #(.C_DATA_WIDTH(W), .C_LANES(L), .C_ID_WIDTH(IDW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tready(s_tready), .s_axis_tvalid(s_valid), .s_axis_tdata(s_data),
    .s_axis_tuser(s_user), .s_axis_tlast(s_last), .s_axis_tid(s_id),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_last), .m_axis_tid(m_id)
`ifdef AXIS_LANE_ADDER_STATS_EN
    , .stat_beats(stat_beats), .stat_pkts(stat_pkts)
`endif
  );

  axis_lane_adder #(.C_DATA_WIDTH(8), .C_LANES(1), .C_ID_WIDTH(8)) dut8 (
    .aclk(aclk), .areset(areset),
    .s_axis_tready(s8_tready), .s_axis_tvalid(s8_valid), .s_axis_tdata(s8_data),
    .s_axis_tuser(s8_user), .s_axis_tlast(s8_last), .s_axis_tid(s8_id),
    .m_axis_tvalid(m8_valid), .m_axis_tready(m8_ready), .m_axis_tdata(m8_tdata),
    .m_axis_tlast(m8_last), .m_axis_tid(m8_id)
`ifdef AXIS_LANE_ADDER_STATS_EN
    , .stat_beats(st8_beats), .stat_pkts(st8_pkts)
`endif
  );

  typedef struct {
    logic             op;
    logic [IN_W-1:0]  data;
    logic             last;
    logic [IDW-1:0]   id;
    logic [OUT_W-1:0] exp;
  } beat_t;

  typedef struct {
    logic                op;
    logic [L-1:0][W-1:0] a;
    logic [L-1:0][W-1:0] b;
    logic [L-1:0][W:0]   exp;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t in_q[$];
  beat_t exp_q[$];
  int    cyc = 0;
  int    acc_n, pop_n, first_pop, last_pop, last_acc;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: 64-bit arithmetic truncated to W+1 bits per lane.
  function automatic logic [OUT_W-1:0] model(input logic op, input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    longint unsigned  av, bv, x;
    r = '0;
    for (int i = 0; i < L; i++) begin
      av = 64'(d[2*i*W +: W]);
      bv = 64'(d[(2*i+1)*W +: W]);
      x  = op ? (av - bv) : (av + bv);
      r[i*(W+1) +: W+1] = x[W:0];
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rnd_data();
    logic [IN_W-1:0] r;
    for (int i = 0; i < IN_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic push(input logic op, input logic [IN_W-1:0] d, input logic last,
                      input logic [IDW-1:0] id, input logic [OUT_W-1:0] exp);
    beat_t b;
    b.op = op; b.data = d; b.last = last; b.id = id; b.exp = exp;
    in_q.push_back(b);
    exp_q.push_back(b);
  endtask

  // mode 0: m_ready=1, mode 1: random m_ready, mode 2: m_ready=0 for the first 5 cycles.
  task automatic run(input int max_cyc, input int mode);
    bit done;
    done = 1'b0;
    acc_n = 0; pop_n = 0; first_pop = -1;
    for (int k = 0; k < max_cyc; k++) begin
      if (in_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge aclk); #1;
      cyc++;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (k >= 5);
      endcase
      if (in_q.size() > 0) begin
        s_valid = 1'b1;
        s_data  = in_q[0].data;
        s_user  = in_q[0].op;
        s_last  = in_q[0].last;
        s_id    = in_q[0].id;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (s_valid && s_tready) begin
        in_q.delete(0);
        acc_n++;
        last_acc = cyc;
      end
      if (mode == 2 && k == 4) begin
        check("stall_tready", 160'(s_tready), 160'(0));
        check("stall_accepts", 160'(acc_n), 160'(2));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 160'(1), 160'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", 160'({m_tdata, m_last, m_id}), 160'({e.exp, e.last, e.id}));
        end
        pop_n++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (in_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    check("run_done", 160'(done), 160'(1));
    if (!done) begin
      in_q.delete();
      exp_q.delete();
      s_valid = 1'b0;
    end
  endtask

  task automatic t8(input logic [7:0] a, input logic [7:0] b, input logic op, input logic [8:0] exp);
    bit found;
    found = 1'b0;
    @(posedge aclk); #1;
    s8_valid = 1'b1; s8_data = {b, a}; s8_user = op;
    #1;
    check("w8_tready", 160'(s8_tready), 160'(1));
    @(posedge aclk); #1;
    s8_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (m8_valid) begin
        found = 1'b1;
        break;
      end
      @(posedge aclk); #1;
    end
    check("w8_valid", 160'(found), 160'(1));
    check("w8_result", 160'(m8_tdata), 160'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t            tbl[4];
    beat_t           bt;
    int              stale;
    logic [IN_W-1:0] d;

    tbl[0].op = 1'b0;
    tbl[0].a   = {32'h8000_0000, 32'h0, 32'h3, 32'hFFFF_FFFF};
    tbl[0].b   = {32'h8000_0000, 32'h0, 32'h4, 32'h0000_0001};
    tbl[0].exp = {33'h1_0000_0000, 33'h0, 33'h0_0000_0007, 33'h1_0000_0000};
    tbl[1].op = 1'b1;
    tbl[1].a   = {32'hFFFF_FFFF, 32'h0, 32'h7, 32'h5};
    tbl[1].b   = {32'h0, 32'h0, 32'h5, 32'h7};
    tbl[1].exp = {33'h0_FFFF_FFFF, 33'h0, 33'h0_0000_0002, 33'h1_FFFF_FFFE};
    tbl[2].op = 1'b1;
    tbl[2].a   = {32'h1, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0};
    tbl[2].b   = {32'h2, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[2].exp = {33'h1_FFFF_FFFF, 33'h0_1234_5677, 33'h0, 33'h1_0000_0001};
    tbl[3].op = 1'b0;
    tbl[3].a   = {32'h0, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3].b   = {32'h0, 32'h5A5A_5A5A, 32'h0, 32'hFFFF_FFFF};
    tbl[3].exp = {33'h0, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFE};

    areset = 1'b1; s_valid = 1'b0; s_data = '0; s_user = 1'b0; s_last = 1'b0; s_id = '0;
    m_ready = 1'b0;
    s8_valid = 1'b0; s8_data = '0; s8_user = 1'b0; s8_last = 1'b0; s8_id = '0; m8_ready = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    check("tready_in_reset", 160'(s_tready), 160'(0));
    check("reset_outputs", 160'({m_valid, m_tdata, m_last, m_id}), 160'(0));
    areset = 1'b0;
    #1;
    check("tready_idle", 160'(s_tready), 160'(1));

    // Hand-computed vectors, one at a time, with latency check.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < L; i++) begin
        d[2*i*W +: W]     = tbl[k].a[i];
        d[(2*i+1)*W +: W] = tbl[k].b[i];
      end
      push(tbl[k].op, d, k[0], 8'(8'h10 + k), OUT_W'(tbl[k].exp));
      run(12, 0);
      check("latency", 160'(last_pop - last_acc), 160'(2));
    end

    // 16 back-to-back beats with no backpressure.
    for (int i = 0; i < 16; i++) begin
      d = rnd_data();
      push(1'(i % 2), d, (i % 4) == 3, 8'(i), model(1'(i % 2), d));
    end
    run(40, 0);
    check("b2b_count", 160'(pop_n), 160'(16));
    check("b2b_consecutive", 160'(last_pop - first_pop), 160'(15));

    // Output stall for 5 cycles while the source keeps pushing.
    for (int i = 0; i < 8; i++) begin
      d = rnd_data();
      push(1'(i / 4), d, i == 7, 8'(8'h40 + i), model(1'(i / 4), d));
    end
    run(40, 2);
    check("stall_count", 160'(pop_n), 160'(8));

    // Reset with two beats in flight.
    @(posedge aclk); #1;
    m_ready = 1'b0; s_valid = 1'b1; s_data = rnd_data(); s_user = 1'b0; s_id = 8'hA0; s_last = 1'b0;
    #1;
    check("inflight_acc0", 160'(s_tready), 160'(1));
    @(posedge aclk); #1;
    s_data = rnd_data(); s_id = 8'hA1; s_last = 1'b1;
    #1;
    check("inflight_acc1", 160'(s_tready), 160'(1));
    @(posedge aclk); #1;
    s_valid = 1'b0; areset = 1'b1;
    #1;
    check("tready_mid_reset", 160'(s_tready), 160'(0));
    @(posedge aclk); #1;
    areset = 1'b0;
    check("flush_outputs", 160'({m_valid, m_tdata, m_last, m_id}), 160'(0));
    m_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge aclk); #1;
      if (m_valid) stale++;
    end
    check("no_stale_beat", 160'(stale), 160'(0));

    // Random backpressure over three packets.
`ifdef AXIS_LANE_ADDER_STATS_EN
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    check("stats_reset", 160'({stat_beats, stat_pkts}), 160'(0));
`endif
    for (int i = 0; i < 10; i++) begin
      d = rnd_data();
      push(1'($urandom_range(0, 1)), d, (i == 2) || (i == 6) || (i == 9), 8'(8'h80 + i), '0);
      bt = exp_q[exp_q.size() - 1];
      exp_q[exp_q.size() - 1].exp = model(bt.op, d);
      in_q[in_q.size() - 1].exp   = model(bt.op, d);
    end
    run(120, 1);
    check("rand_count", 160'(pop_n), 160'(10));
    @(posedge aclk); #1;
    m_ready = 1'b1;
`ifdef AXIS_LANE_ADDER_STATS_EN
    check("stat_beats", 160'(stat_beats), 160'(10));
    check("stat_pkts", 160'(stat_pkts), 160'(3));
`endif

    // Single-lane 8-bit build.
    t8(8'hFF, 8'hFF, 1'b0, 9'h1FE);
    t8(8'h00, 8'h01, 1'b1, 9'h1FF);
    t8(8'h80, 8'h7F, 1'b0, 9'h0FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
